// File: rtl/mem_resp.sv
// Memory-side responder: unified word RAM for fetch/load/store plus an MMIO window
// with a console TX FIFO and, when MEM_RESP_TIMER_EN is defined, a 64-bit machine timer.
module mem_resp #(
  parameter int          XLEN        = 32,
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  output logic [31:0]     inst,
  input  logic [XLEN-1:0] address,
  input  logic            mem_load,
  input  logic            mem_store,
  input  logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic            irq_timer
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  localparam logic [5:0] OFF_CON_DATA = 6'h00;
  localparam logic [5:0] OFF_CON_STAT = 6'h01;
  localparam logic [5:0] OFF_MTIME_LO = 6'h02;
  localparam logic [5:0] OFF_MTIME_HI = 6'h03;
  localparam logic [5:0] OFF_MCMP_LO  = 6'h04;
  localparam logic [5:0] OFF_MCMP_HI  = 6'h05;

  // mem_load carries no information here: reads are side-effect free
  logic unused_sig;
  assign unused_sig = ^{mem_load, pc, address, store_data};

  logic            mmio_hit;
  logic [5:0]      off;
  logic [AW-1:0]   pc_idx;
  logic [AW-1:0]   ad_idx;
  logic            ram_we;
  logic            mmio_we;

  assign mmio_hit = (address[XLEN-1:8] == MMIO_BASE[XLEN-1:8]);
  assign off      = address[7:2];
  assign pc_idx   = pc[AW+1:2];
  assign ad_idx   = address[AW+1:2];
  assign ram_we   = mem_store && !mmio_hit;
  assign mmio_we  = mem_store && mmio_hit;

  // ---------------------------------------------------------------- RAM
  logic [XLEN-1:0] ram_q [DEPTH_WORDS];

  always_ff @(posedge clock) begin
    if (ram_we) ram_q[ad_idx] <= store_data;
  end

  assign inst = ram_q[pc_idx];

  // ---------------------------------------------------------------- console FIFO
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          fifo_empty, fifo_full;
  logic          pop, push_req, push, stat_we;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign tx_valid   = !fifo_empty;
  // gated so the head reads 0 after reset without clearing the storage
  assign tx_data    = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];

  assign pop      = tx_valid && tx_ready;
  assign push_req = mmio_we && (off == OFF_CON_DATA);
  assign push     = push_req && (!fifo_full || pop);
  assign stat_we  = mmio_we && (off == OFF_CON_STAT);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: ;
    endcase
    if (stat_we && store_data[2]) ovf_d = 1'b0;
    // an overflow in the same cycle as a clear leaves ovf set
    if (push_req && !push)        ovf_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= store_data[7:0];
  end

  // ---------------------------------------------------------------- timer
  logic [XLEN-1:0] timer_rdata;

`ifdef MEM_RESP_TIMER_EN
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        irq_q, irq_d;

  always_comb begin
    mtime_d    = mtime_q + 64'd1;
    mtimecmp_d = mtimecmp_q;
    if (mmio_we) begin
      case (off)
        OFF_MTIME_LO: mtime_d    = {mtime_q[63:32], store_data};
        OFF_MTIME_HI: mtime_d    = {store_data, mtime_q[31:0]};
        OFF_MCMP_LO:  mtimecmp_d = {mtimecmp_q[63:32], store_data};
        OFF_MCMP_HI:  mtimecmp_d = {store_data, mtimecmp_q[31:0]};
        default: ;
      endcase
    end
    irq_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    timer_rdata = '0;
    case (off)
      OFF_MTIME_LO: timer_rdata = mtime_q[31:0];
      OFF_MTIME_HI: timer_rdata = mtime_q[63:32];
      OFF_MCMP_LO:  timer_rdata = mtimecmp_q[31:0];
      OFF_MCMP_HI:  timer_rdata = mtimecmp_q[63:32];
      default: ;
    endcase
  end

  assign irq_timer = irq_q;
`else
  assign timer_rdata = '0;
  assign irq_timer   = 1'b0;
`endif

  // ---------------------------------------------------------------- load path
  logic [XLEN-1:0] mmio_rdata;

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_CON_STAT: mmio_rdata = {{(XLEN-3){1'b0}}, ovf_q, fifo_empty, fifo_full};
      OFF_MTIME_LO, OFF_MTIME_HI,
      OFF_MCMP_LO,  OFF_MCMP_HI: mmio_rdata = timer_rdata;
      default: ;
    endcase
  end

  assign load_data = mmio_hit ? mmio_rdata : ram_q[ad_idx];

endmodule

// File: doc/mem_resp.md
# mem_resp

Memory-side responder for the core's instruction and data ports. It holds a unified word RAM that serves instruction fetch and load/store, plus a small MMIO window with a console transmit FIFO and a 64-bit machine timer. Reads are combinational, matching the core's single-cycle MEM stage. Writes commit on the clock edge. The block sits directly outside the core, wired to `pc`/`inst` and `address`/`mem_load`/`mem_store`/`store_data`/`load_data`.

## Interface
- `XLEN`, 32: data width; only 32 is supported.
- `DEPTH_WORDS`, 4096: RAM depth in words; power of two.
- `MMIO_BASE`, 32'h1000_0000: base of the MMIO window; 256-byte aligned.
- `FIFO_DEPTH`, 8: console FIFO entries; power of two, at least 2.

- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low.
- `pc` input XLEN: fetch address.
- `inst` output 32: fetched word.
- `address` input XLEN: data address.
- `mem_load` input 1: load in progress; informational only, because reads have no side effects.
- `mem_store` input 1: write `store_data` at `address` this cycle.
- `store_data` input XLEN: full merged word; the core has already done the byte-lane merge.
- `load_data` output XLEN: word at `address`.
- `tx_valid` output 1: console FIFO head is valid.
- `tx_data` output 8: console FIFO head byte.
- `tx_ready` input 1: consumer accepts the head byte.
- `irq_timer` output 1: registered timer interrupt.

## Operation
- **Address decode**
  - MMIO hit: `address[XLEN-1:8] == MMIO_BASE[XLEN-1:8]`. Everything else is RAM.
  - RAM index: `address[log2(DEPTH_WORDS)+1:2]`. Upper bits alias, so addresses wrap.
  - `address[1:0]` is ignored.
- **Fetch**
  - `inst = ram[pc index]`, combinational.
  - The fetch port never sees MMIO; `pc` in the MMIO window returns RAM aliased by index.
- **Load**
  - `load_data` is combinational from `address` every cycle, whatever `mem_load` is. The core needs this for the store read-modify-write.
- **Store**
  - When `mem_store` is high, the whole word is written at the edge.
  - A RAM write is visible to both `load_data` and `inst` from the next cycle.
- **MMIO map** (byte offset: read / write behaviour):
  - 0x00 `CON_DATA`
    - Read: 0.
    - Write: enqueue `store_data[7:0]`.
    - The write is accepted if count < `FIFO_DEPTH`, or if a pop (`tx_valid && tx_ready`) happens in the same cycle.
    - Otherwise the byte is dropped and sticky `ovf` is set.
  - 0x04 `CON_STAT`
    - Read: `{29'b0, ovf, empty, full}`.
    - Write: `store_data[2]=1` clears `ovf`.
  - 0x08 / 0x0C `MTIME_LO` / `MTIME_HI`: read or write the matching half of `mtime`.
  - 0x10 / 0x14 `MTIMECMP_LO` / `MTIMECMP_HI`: read or write the matching half of `mtimecmp`.
  - Other offsets: read 0, writes ignored.
- **Timer**
  - `mtime` increments by 1 every cycle, wrapping modulo 2^64.
  - A write to either half in a cycle replaces the increment for that cycle: the written half takes `store_data`, and the other half holds.
- **Interrupt**
  - `irq_timer` is registered: `irq_timer <= (mtime_next >= mtimecmp_next)`, unsigned 64-bit compare on post-edge values.
- **Console FIFO**
  - Circular buffer with read and write pointers and a count.
  - `tx_valid = !empty`; `tx_data` is the head byte.
  - On a pop, head advances.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - A `CON_STAT` write that clears `ovf` in the same cycle as an overflow event: set wins.

## Timing
- **Reset values** (asserting `reset` mid-operation drops all queued bytes and returns to these values):
  - FIFO empty; `tx_valid` = 0; `tx_data` = 0.
  - `ovf` = 0.
  - `mtime` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `irq_timer` = 0.
- **Not reset**
  - RAM contents.
  - `inst` and `load_data`, which follow their addresses combinationally.
- **Latency**
  - Reads: 0 cycles.
  - Writes: visible 1 cycle later.
  - A byte written at edge N gives `tx_valid` = 1 after edge N when the FIFO was empty.
  - An `mtime` write at edge N reads back as the value+1 after edge N+1.
- **Handshake**
  - `tx_data` is stable while `tx_valid && !tx_ready`.
  - The consumer may hold `tx_ready` high continuously, giving 1 byte per cycle.

## Configuration
- `MEM_RESP_TIMER_EN`
  - Defined: `mtime`, `mtimecmp` and `irq_timer` are implemented as above.
  - Undefined: no timer registers; offsets 0x08–0x14 read 0 and ignore writes; `irq_timer` is tied to 0.
  - RAM and console behaviour are identical in both builds.

## Test plan
- **RAM store/load:** store 32'hDEAD_BEEF at 0x40. Next cycle `load_data` = 32'hDEAD_BEEF at address 0x40, and `inst` = 32'hDEAD_BEEF with `pc` = 0x40. Address `0x40 + 4*DEPTH_WORDS` reads the same word (aliasing).
- **FIFO full/overflow:** with `tx_ready` = 0, write bytes 0x01..0x09 to `CON_DATA`. `CON_STAT` reads 3'b101 (ovf, full). Raising `tx_ready` drains 0x01..0x08 on consecutive cycles, then `tx_valid` = 0 and `CON_STAT` reads 3'b110 (ovf, empty). Writing 4 to `CON_STAT` clears `ovf`.
- **Full with simultaneous pop:** FIFO full, `tx_ready` = 1, write 0xAA. The write is accepted, `ovf` stays 0, 0xAA is emitted 8th after the current head.
- **Timer:** write `MTIMECMP_HI` = 0 and `MTIMECMP_LO` = 100, then `MTIME_LO` = 90 with `MTIME_HI` = 0. `irq_timer` rises on the edge where `mtime` reaches 100 (10 cycles after the `MTIME_LO` write) and stays high until `mtimecmp` is rewritten larger.
- **Reset mid-operation:** with 3 bytes queued and `mtime` ≈ 500, pulse `reset` low asynchronously. `tx_valid`, `irq_timer` and `mtime` go to 0 immediately, without waiting for a clock edge. RAM data is preserved.
- **Macro off:** build without `MEM_RESP_TIMER_EN`. Offset 0x08 reads 0 after a write of 5, and `irq_timer` stays 0 throughout.
